// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter and access sequencer for the byte-lane data memory.
// Build option: define DMEM_ARB_RR_EN for round-robin conflicts; otherwise port 0 has fixed priority.

module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [2:0]        p0_req_func3,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    output logic              p0_resp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [2:0]        p1_req_func3,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              p1_resp_err,

    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_dmwen,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] RESP   = 2'b10;

    logic [1:0]        state;

    logic              req_we_p0;
    logic [2:0]        req_func3_p0;
    logic [ADDR_W-3:0] req_word_p0;
    logic [DATA_W-1:0] req_wdata_p0;
    logic              req_port_p0;
    logic              req_err_p0;

    logic              can_accept;
    logic              grant;
    logic              win_port;
    logic              vld_p0;
    logic              vld_p1;

    logic              sel_we;
    logic [2:0]        sel_func3;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic [DATA_W-1:0] resp_data;

    function automatic logic req_illegal(input logic [2:0] func3, input logic [1:0] addr_lo);
        return (addr_lo != 2'b00) || (func3 > 3'b010);
    endfunction

    // Accept stage: arbitration and request selection, combinational in IDLE or RESP
    assign can_accept = rst_n && ((state == IDLE) || (state == RESP));
    assign grant      = can_accept && (p0_req_valid || p1_req_valid);

`ifdef DMEM_ARB_RR_EN
    logic last_port;

    // Pointer resets to 1 so that port 0 takes the first conflict.
    assign win_port = (p0_req_valid && p1_req_valid) ? ~last_port : ~p0_req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_port <= 1'b1;
        end else if (grant) begin
            last_port <= win_port;
        end
    end
`else
    assign win_port = ~p0_req_valid;
`endif

    assign p0_req_ready = grant && !win_port;
    assign p1_req_ready = grant &&  win_port;

    always_comb begin
        sel_we    = p0_req_we;
        sel_func3 = p0_req_func3;
        sel_addr  = p0_req_addr;
        sel_wdata = p0_req_wdata;
        if (win_port) begin
            sel_we    = p1_req_we;
            sel_func3 = p1_req_func3;
            sel_addr  = p1_req_addr;
            sel_wdata = p1_req_wdata;
        end
        sel_err = req_illegal(sel_func3, sel_addr[1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_we_p0    <= 1'b0;
            req_func3_p0 <= 3'b000;
            req_word_p0  <= '0;
            req_wdata_p0 <= '0;
            req_port_p0  <= 1'b0;
            req_err_p0   <= 1'b0;
        end else begin
            case (state)
                IDLE:    state <= grant ? ACCESS : IDLE;
                ACCESS:  state <= RESP;
                RESP:    state <= grant ? ACCESS : IDLE;
                default: state <= IDLE;
            endcase
            if (grant) begin
                req_we_p0    <= sel_we;
                req_func3_p0 <= sel_func3;
                req_word_p0  <= sel_addr[ADDR_W-1:2];
                req_wdata_p0 <= sel_wdata;
                req_port_p0  <= win_port;
                req_err_p0   <= sel_err;
            end
        end
    end

    // Access stage: memory inputs follow the latched request; only the write enable is state-gated
    assign vld_p0    = (state == ACCESS);
    assign mem_addr  = {2'b00, req_word_p0};
    assign mem_func3 = req_func3_p0;
    assign mem_wdata = req_wdata_p0;
    assign mem_dmwen = vld_p0 && req_we_p0 && !req_err_p0;

    // Response stage: memory output is already registered, so it is forwarded directly
    assign vld_p1    = (state == RESP);
    assign resp_data = (vld_p1 && !req_we_p0 && !req_err_p0) ? mem_rdata : '0;

    assign p0_resp_valid = vld_p1 && !req_port_p0;
    assign p0_resp_rdata = req_port_p0 ? '0 : resp_data;
    assign p0_resp_err   = vld_p1 && !req_port_p0 && req_err_p0;

    assign p1_resp_valid = vld_p1 && req_port_p0;
    assign p1_resp_rdata = req_port_p0 ? resp_data : '0;
    assign p1_resp_err   = vld_p1 && req_port_p0 && req_err_p0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed cases plus randomized two-port traffic against a byte-level model.
// A scoreboard queue per port holds expected responses; a forked monitor pops and compares them.

module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        p0_req_valid, p0_req_ready, p0_req_we;
    logic [2:0]  p0_req_func3;
    logic [31:0] p0_req_addr, p0_req_wdata;
    logic        p0_resp_valid, p0_resp_err;
    logic [31:0] p0_resp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we;
    logic [2:0]  p1_req_func3;
    logic [31:0] p1_req_addr, p1_req_wdata;
    logic        p1_resp_valid, p1_resp_err;
    logic [31:0] p1_resp_rdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_dmwen;
    logic [31:0] mem_rdata = 32'h0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_func3(p0_req_func3), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_func3(p1_req_func3), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dmwen(mem_dmwen), .mem_rdata(mem_rdata)
    );

    // Byte-lane data memory: word-indexed, registered read output
    logic [31:0] mem_arr [0:1023] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_dmwen) begin
            case (mem_func3)
                3'b000:  mem_arr[mem_addr[9:0]][7:0]  <= mem_wdata[7:0];
                3'b001:  mem_arr[mem_addr[9:0]][15:0] <= mem_wdata[15:0];
                default: mem_arr[mem_addr[9:0]]       <= mem_wdata;
            endcase
        end
        case (mem_func3)
            3'b000:  mem_rdata <= {24'h0, mem_arr[mem_addr[9:0]][7:0]};
            3'b001:  mem_rdata <= {16'h0, mem_arr[mem_addr[9:0]][15:0]};
            default: mem_rdata <= mem_arr[mem_addr[9:0]];
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  ref_mem [0:4095] = '{default: 8'h0};
    int          last_acc = -100;
    logic        rr_last = 1'b1;
    int          acc_cyc = -100;
    logic        acc_wr = 1'b0;
    logic [31:0] acc_word = 32'h0;
    logic        undo_v = 1'b0;
    int          undo_cyc = 0;
    int          undo_n = 0;
    logic [11:0] undo_a = 12'h0;
    logic [7:0]  undo_b [0:3];
    int          grant_log[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    function automatic int fsize(input logic [2:0] f3);
        return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    endfunction

    task automatic chk_resp(input int p, input logic v, input logic [31:0] rd, input logic e);
        exp_t x;
        logic have;
        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) x = (p == 0) ? q0[0] : q1[0];
        if (v) begin
            if (!have) begin
                fail_now($sformatf("resp_unexpected_p%0d: got resp_valid 1, required 0", p));
            end else begin
                if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check($sformatf("resp_cycle_p%0d", p), cyc, x.due);
                check($sformatf("resp_rdata_p%0d", p), rd, x.rdata);
                check($sformatf("resp_err_p%0d", p), {31'h0, e}, {31'h0, x.err});
            end
        end else if (have && x.due <= cyc) begin
            fail_now($sformatf("resp_missing_p%0d: got resp_valid 0, required 1", p));
            if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    // Reference model: an accepted request owns the memory for two cycles, one at a time.
    task automatic monitor();
        logic        exp_wr, allowed, v0, v1, win, we, err;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          n;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (undo_v && undo_cyc >= cyc - 1)
                    for (int i = 0; i < undo_n; i++) ref_mem[undo_a + 12'(i)] = undo_b[i];
                undo_v   = 1'b0;
                q0.delete();
                q1.delete();
                last_acc = -100;
                acc_cyc  = -100;
                rr_last  = 1'b1;
            end else begin
                exp_wr = (acc_cyc == cyc - 1) && acc_wr;
                check("mem_dmwen", {31'h0, mem_dmwen}, {31'h0, exp_wr});
                if (exp_wr) check("mem_addr", mem_addr, acc_word);
                chk_resp(0, p0_resp_valid, p0_resp_rdata, p0_resp_err);
                chk_resp(1, p1_resp_valid, p1_resp_rdata, p1_resp_err);

                allowed = (cyc - last_acc) >= 2;
                v0 = p0_req_valid;
                v1 = p1_req_valid;
`ifdef DMEM_ARB_RR_EN
                win = (v0 && v1) ? ~rr_last : ~v0;
`else
                win = ~v0;
`endif
                check("p0_req_ready", {31'h0, p0_req_ready}, {31'h0, allowed && v0 && !win});
                check("p1_req_ready", {31'h0, p1_req_ready}, {31'h0, allowed && v1 && win});
                if (p0_req_valid && p0_req_ready) grant_log.push_back(0);
                if (p1_req_valid && p1_req_ready) grant_log.push_back(1);

                if (allowed && (v0 || v1)) begin
                    we  = win ? p1_req_we    : p0_req_we;
                    f3  = win ? p1_req_func3 : p0_req_func3;
                    a   = win ? p1_req_addr  : p0_req_addr;
                    wd  = win ? p1_req_wdata : p0_req_wdata;
                    err = (a % 4 != 0) || (f3 > 3'd2);
                    n   = fsize(f3);
                    e.due   = cyc + 2;
                    e.err   = err;
                    e.rdata = 32'h0;
                    if (!err && !we)
                        for (int i = 0; i < n; i++)
                            e.rdata = e.rdata + (32'(ref_mem[a[11:0] + 12'(i)]) << (8 * i));
                    if (!err && we) begin
                        undo_v = 1'b1; undo_cyc = cyc; undo_a = a[11:0]; undo_n = n;
                        for (int i = 0; i < n; i++) begin
                            undo_b[i] = ref_mem[a[11:0] + 12'(i)];
                            ref_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
                        end
                    end
                    if (win) q1.push_back(e); else q0.push_back(e);
                    acc_cyc  = cyc;
                    acc_wr   = we && !err;
                    acc_word = a / 4;
                    last_acc = cyc;
                    rr_last  = win;
                end
            end
        end
    endtask

    task automatic send(input int p, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output int acc);
        acc = -1;
        if (p == 0) begin
            p0_req_valid = 1'b1; p0_req_we = we; p0_req_func3 = f3; p0_req_addr = a; p0_req_wdata = wd;
        end else begin
            p1_req_valid = 1'b1; p1_req_we = we; p1_req_func3 = f3; p1_req_addr = a; p1_req_wdata = wd;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((p == 0 && p0_req_ready) || (p == 1 && p1_req_ready)) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) fail_now($sformatf("accept_timeout_p%0d: got no ready, required ready", p));
        @(posedge clk);
        #1;
        if (p == 0) p0_req_valid = 1'b0; else p1_req_valid = 1'b0;
    endtask

    task automatic req(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
        int acc, rc;
        send(p, we, f3, a, wd, acc);
        rc = -1; rd = 32'h0; e = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((p == 0) ? p0_resp_valid : p1_resp_valid) begin
                rc = cyc;
                rd = (p == 0) ? p0_resp_rdata : p1_resp_rdata;
                e  = (p == 0) ? p0_resp_err : p1_resp_err;
                break;
            end
        end
        if (rc < 0) fail_now($sformatf("resp_timeout_p%0d: got no resp_valid, required one", p));
        lat = rc - acc;
        @(posedge clk);
        #1;
    endtask

    task automatic port_rand(input int p);
        int          g, r, acc;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
            g = $urandom_range(0, 3);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            r  = $urandom_range(0, 9);
            f3 = (r < 3) ? 3'(r) : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
            a  = 32'($urandom_range(0, 1023)) * 4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            send(p, 1'($urandom_range(0, 1)), f3, a, $urandom, acc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e, seen;
        int          lat, a1, a2, a3, gl_start;
        int          exp_order[4];

        rst_n = 1'b0;
        p0_req_valid = 0; p0_req_we = 0; p0_req_func3 = 0; p0_req_addr = 0; p0_req_wdata = 0;
        p1_req_valid = 0; p1_req_we = 0; p1_req_func3 = 0; p1_req_addr = 0; p1_req_wdata = 0;
        fork
            monitor();
        join_none

        #2 p0_req_valid = 1'b1;
        #10;
        check("rst_p0_ready", {31'h0, p0_req_ready}, 0);
        check("rst_p1_ready", {31'h0, p1_req_ready}, 0);
        check("rst_resp_valid", {30'h0, p0_resp_valid, p1_resp_valid}, 0);
        check("rst_resp_err", {30'h0, p0_resp_err, p1_resp_err}, 0);
        check("rst_resp_rdata", p0_resp_rdata | p1_resp_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_func3", {29'h0, mem_func3}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_dmwen", {31'h0, mem_dmwen}, 0);
        p0_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        req(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, e, lat);
        check("sw_latency", lat, 2);
        check("sw_err", {31'h0, e}, 0);
        check("sw_rdata", rd, 0);
        req(0, 1'b0, 3'b010, 32'h100, 32'h0, rd, e, lat);
        check("lw_latency", lat, 2);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", {31'h0, e}, 0);

        req(1, 1'b1, 3'b000, 32'h104, 32'h55, rd, e, lat);
        req(1, 1'b0, 3'b010, 32'h104, 32'h0, rd, e, lat);
        check("p1_lw_after_sb", rd, 32'h00000055);
        check("p1_lw_latency", lat, 2);

        req(0, 1'b0, 3'b010, 32'h102, 32'h0, rd, e, lat);
        check("misalign_err", {31'h0, e}, 1);
        check("misalign_rdata", rd, 0);
        req(0, 1'b0, 3'b100, 32'h100, 32'h0, rd, e, lat);
        check("func3_err", {31'h0, e}, 1);
        check("func3_rdata", rd, 0);
        req(0, 1'b1, 3'b010, 32'h101, 32'h12345678, rd, e, lat);
        check("bad_store_err", {31'h0, e}, 1);
        req(0, 1'b0, 3'b010, 32'h100, 32'h0, rd, e, lat);
        check("bad_store_no_write", rd, 32'hDEADBEEF);

        send(0, 1'b0, 3'b010, 32'h100, 32'h0, a1);
        send(0, 1'b0, 3'b010, 32'h104, 32'h0, a2);
        send(0, 1'b1, 3'b001, 32'h108, 32'hBEEF, a3);
        check("b2b_spacing_1", a2 - a1, 2);
        check("b2b_spacing_2", a3 - a2, 2);
        repeat (4) @(posedge clk);
        #1;

        req(1, 1'b0, 3'b010, 32'h104, 32'h0, rd, e, lat);
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        gl_start = grant_log.size();
        fork
            begin
                for (int k = 0; k < 4; k++) send(0, 1'b0, 3'b010, 32'h100, 32'h0, a1);
            end
            begin
                for (int k = 0; k < 4; k++) send(1, 1'b0, 3'b010, 32'h104, 32'h0, a2);
            end
        join
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_order_%0d", i),
                  (gl_start + i < grant_log.size()) ? grant_log[gl_start + i] : -1, exp_order[i]);
        repeat (4) @(posedge clk);
        #1;

        req(0, 1'b1, 3'b010, 32'h200, 32'hA5A5A5A5, rd, e, lat);
        p0_req_we = 1'b1; p0_req_func3 = 3'b010; p0_req_addr = 32'h200; p0_req_wdata = 32'h0BADF00D;
        p0_req_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_accept", {31'h0, p0_req_ready}, 1);
        @(posedge clk);
        #1;
        p0_req_valid = 1'b0;
        check("rst_mid_dmwen_before", {31'h0, mem_dmwen}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_dmwen_after", {31'h0, mem_dmwen}, 0);
        check("rst_mid_resp_valid", {30'h0, p0_resp_valid, p1_resp_valid}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | p0_resp_valid | p1_resp_valid;
        end
        check("rst_mid_no_resp", {31'h0, seen}, 0);
        @(posedge clk);
        #1;
        req(0, 1'b0, 3'b010, 32'h200, 32'h0, rd, e, lat);
        check("rst_mid_old_data", rd, 32'hA5A5A5A5);

        fork
            port_rand(0);
            port_rand(1);
        join
        repeat (6) @(posedge clk);
        #1;
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-lane data memory. It accepts load/store requests from two requesters, port 0 (CPU load/store unit) and port 1 (debug/DMA), over valid/ready handshakes. It grants one request at a time and drives the memory's `func3`/`addr`/`wdata`/`dmwen` inputs. It returns the memory's registered read data, or a write acknowledge, to the winning port one cycle after the access.

## Interface
Parameters:
- `ADDR_W`, default 32: requester byte-address width.
- `DATA_W`, default 32: data width; fixed at 32 and must not be overridden.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pN_req_valid` in 1 (N = 0, 1): request present.
- `pN_req_ready` out 1: request accepted this cycle when high together with valid.
- `pN_req_we` in 1: 1 = store, 0 = load.
- `pN_req_func3` in 3: access size; 000 = byte, 001 = half, 010 = word.
- `pN_req_addr` in 32: byte address.
- `pN_req_wdata` in 32: store data, right-aligned.
- `pN_resp_valid` out 1: one-cycle completion pulse.
- `pN_resp_rdata` out 32: load data, zero-extended by the memory; 0 for stores and errors.
- `pN_resp_err` out 1: request rejected (misaligned address or illegal func3); qualified by resp_valid.
- `mem_func3` out 3: to memory `func3`.
- `mem_addr` out 32: to memory `addr`; word index.
- `mem_wdata` out 32: to memory `wdata`.
- `mem_dmwen` out 1: to memory `dmwen`.
- `mem_rdata` in 32: from memory `out`; valid the cycle after the access cycle.

## Operation
- FSM states:
  - IDLE: may accept.
  - ACCESS: memory cycle.
  - RESP: response cycle; may also accept the next request.
- Accepting (IDLE or RESP):
  - If any `pN_req_valid` is set, the winner gets `pN_req_ready` = 1, combinationally, the same cycle.
  - The loser's ready is 0.
  - The request is latched: we, func3, addr, wdata, port id, err.
  - Next state is ACCESS.
  - In RESP with no valid request, next state is IDLE.
- Error check at acceptance: `err` = (addr[1:0] != 00) or func3 not in {000, 001, 010}.
- ACCESS:
  - `mem_addr` = {2'b00, addr[31:2]}.
  - `mem_func3` = latched func3.
  - `mem_wdata` = latched wdata.
  - `mem_dmwen` = we & ~err.
  - Always goes to RESP.
- RESP:
  - `pG_resp_valid` = 1 for the granted port G only.
  - `resp_rdata` = `mem_rdata` for an error-free load, else 0.
  - `resp_err` = latched err.
- Outside ACCESS, `mem_dmwen` = 0. `mem_addr`, `mem_func3` and `mem_wdata` hold their last latched values.
- Errored requests follow the same timing and never write memory.
- Requesters must hold their fields stable while valid && !ready.

## Timing
- Reset values:
  - State IDLE.
  - All `pN_req_ready`, `pN_resp_valid` and `pN_resp_err` = 0.
  - `pN_resp_rdata` = 0.
  - `mem_*` outputs = 0.
  - Priority pointer: port 0 wins first.
- Latency: accept in cycle T, ACCESS in T+1, resp_valid in T+2.
- Throughput: one access per 2 cycles per arbiter, achieved by accepting during RESP.
- Simultaneous valid on both ports: resolved by the priority rule (see Configuration).
- Simultaneous resp_valid and a new acceptance on the same port in RESP: both occur.
- Reset asserted mid-operation:
  - Outputs clear immediately, including `mem_dmwen`.
  - The in-flight access is dropped; no resp_valid follows.
  - A store whose ACCESS cycle is cut by reset before the clock edge is not written.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin.
  - A one-bit pointer records the last granted port.
  - On conflict, the other port wins.
  - The pointer updates only on grant.
  - Reset value makes port 0 win the first conflict.
- Undefined: fixed priority. Port 0 always wins conflicts; no pointer register exists.

## Test plan
- Port 0 store word: addr 0x100, wdata 0xDEADBEEF, func3 010. Then load word from 0x100. Required: resp_valid at T+2 for each, load rdata 0xDEADBEEF, err 0.
- Port 1 store byte: 0x55 to 0x104. Then load word from 0x104. Required: rdata 0x00000055 if upper lanes were 0.
- Both ports valid for 4 consecutive grants:
  - With `DMEM_ARB_RR_EN`: grant order 0, 1, 0, 1.
  - Without: 0, 0, 0, 0, with port 1 ready held low.
- Port 0 load from addr 0x102, and a load with func3 100. Required: resp_err = 1, rdata 0, `mem_dmwen` never asserted.
- Back-to-back requests: a new request is accepted in the RESP cycle. Required: accept, ACCESS, RESP+accept, ACCESS, RESP, i.e. 2-cycle spacing.
- `rst_n` pulled low during the ACCESS cycle of a store. Required: `mem_dmwen` drops immediately, no resp_valid, and a subsequent load returns the old data.
